// File: rtl/dm_trace_prefetch_issuer.sv
// dm_trace_prefetch_issuer: replays trace entries as prefetch commands, then marks each entry done.
// Optional statistics counters are enabled by defining DM_TRACE_PREFETCH_ISSUER_STATS_EN.
module dm_trace_prefetch_issuer #(
    parameter int DATA_ADDR_WIDTH = 16,
    parameter int DATA_DATA_WIDTH = 32,
    parameter int CANCEL_TIMEOUT  = 64,
    parameter int TRACE_ENTRIES   = 16,
    localparam int IW = $clog2(TRACE_ENTRIES)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       done,
    output logic                                       trace_req,
    output logic                                       cancel,
    input  logic [DATA_ADDR_WIDTH+DATA_DATA_WIDTH-1:0] trace_out,
    input  logic [IW-1:0]                              trace_index_i,
    input  logic                                       entry_valid,
    input  logic                                       cancelled,
    input  logic                                       processing_complete,
    output logic [IW-1:0]                              index_done,
    output logic                                       mark_done,
    output logic                                       processing_flag,
    output logic                                       mem_trace_flag,
    output logic [DATA_ADDR_WIDTH-1:0]                 mem_addr,
    input  logic                                       mark_done_valid,
    output logic                                       pf_valid,
    input  logic                                       pf_ready,
    output logic [DATA_ADDR_WIDTH-1:0]                 pf_addr,
    output logic [IW-1:0]                              pf_index,
    output logic [15:0]                                issued_count,
    output logic [15:0]                                cancel_count
);
    typedef enum logic [2:0] {IDLE, REARM, REQUEST, ISSUE, MARK, DONE} state_t;
    localparam logic [15:0] TMAX = 16'(CANCEL_TIMEOUT - 1);

    state_t state, nxt;
    logic [15:0] tcnt;
    logic [DATA_ADDR_WIDTH-1:0] lat_addr;
    logic [IW-1:0] lat_idx;
    logic unused_instr;
    logic take_entry, take_cancel, take_pf;

    assign unused_instr = ^trace_out[DATA_DATA_WIDTH-1:0];
    assign take_entry  = state == REQUEST && entry_valid && !processing_complete;
    assign take_cancel = state == REQUEST && cancelled && !entry_valid && !processing_complete;
    assign take_pf     = state == ISSUE && pf_ready;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? REARM : IDLE;
            REARM:   nxt = REQUEST;
            REQUEST: nxt = processing_complete ? DONE : entry_valid ? ISSUE : cancelled ? REARM : REQUEST;
            ISSUE:   nxt = pf_ready ? MARK : ISSUE;
            MARK:    nxt = mark_done_valid ? REARM : MARK;
            DONE:    nxt = start ? REARM : DONE;
            default: nxt = IDLE;
        endcase
    end

    // The timeout counter parks at its terminal value so cancel stays high until REQUEST is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tcnt     <= '0;
            lat_addr <= '0;
            lat_idx  <= '0;
        end else begin
            state <= nxt;
            if (state == REARM)
                tcnt <= '0;
            else if (state == REQUEST && tcnt != TMAX)
                tcnt <= tcnt + 16'd1;
            if (take_entry) begin
                lat_addr <= trace_out[DATA_ADDR_WIDTH+DATA_DATA_WIDTH-1:DATA_DATA_WIDTH];
                lat_idx  <= trace_index_i;
            end
        end
    end

    assign trace_req       = state == REQUEST;
    assign cancel          = trace_req && tcnt == TMAX;
    assign pf_valid        = state == ISSUE;
    assign mark_done       = state == MARK;
    assign processing_flag = mark_done;
    assign mem_trace_flag  = mark_done;
    assign done            = state == DONE;
    assign pf_addr         = lat_addr;
    assign pf_index        = lat_idx;
    assign mem_addr        = lat_addr;
    assign index_done      = lat_idx;

`ifdef DM_TRACE_PREFETCH_ISSUER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_count <= '0;
            cancel_count <= '0;
        end else begin
            if (take_pf && issued_count != 16'hFFFF)
                issued_count <= issued_count + 16'd1;
            if (take_cancel && cancel_count != 16'hFFFF)
                cancel_count <= cancel_count + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = take_pf ^ take_cancel;
    assign issued_count = '0;
    assign cancel_count = '0;
`endif
endmodule

// File: tb/tb_dm_trace_prefetch_issuer.sv
// tb_dm_trace_prefetch_issuer: randomized replay passes checked against a transaction-level model.
module tb_dm_trace_prefetch_issuer;
    localparam int T  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 0, rst = 1, start = 0;
    logic done, trace_req, cancel, mark_done, processing_flag, mem_trace_flag, pf_valid;
    logic [AW+DW-1:0] trace_out = '0;
    logic [IW-1:0] trace_index_i = '0, index_done, pf_index;
    logic entry_valid = 0, cancelled = 0, processing_complete = 0, mark_done_valid = 0, pf_ready = 0;
    logic [AW-1:0] mem_addr, pf_addr;
    logic [15:0] issued_count, cancel_count;

    int n_cmp = 0, n_bad = 0;
    int m_issued = 0, m_cancel = 0;

    dm_trace_prefetch_issuer #(.DATA_ADDR_WIDTH(AW), .DATA_DATA_WIDTH(DW), .CANCEL_TIMEOUT(T), .TRACE_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .trace_req(trace_req), .cancel(cancel),
        .trace_out(trace_out), .trace_index_i(trace_index_i), .entry_valid(entry_valid),
        .cancelled(cancelled), .processing_complete(processing_complete), .index_done(index_done),
        .mark_done(mark_done), .processing_flag(processing_flag), .mem_trace_flag(mem_trace_flag),
        .mem_addr(mem_addr), .mark_done_valid(mark_done_valid), .pf_valid(pf_valid), .pf_ready(pf_ready),
        .pf_addr(pf_addr), .pf_index(pf_index), .issued_count(issued_count), .cancel_count(cancel_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef DM_TRACE_PREFETCH_ISSUER_STATS_EN
        return (v > 65535) ? 32'hFFFF : 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check_counts;
        check("issued_count", {16'd0, issued_count}, exp_cnt(m_issued));
        check("cancel_count", {16'd0, cancel_count}, exp_cnt(m_cancel));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, {27'd0, trace_req, cancel, pf_valid, mark_done, processing_flag | mem_trace_flag}, 32'd0);
    endtask

    // Enters at REQUEST cycle 1; resp: 0 entry, 1 cancelled, 2 complete, 3 complete with entry.
    task automatic request_phase(input int wait_c, input int resp, input logic [AW-1:0] a, input logic [IW-1:0] i);
        for (int k = 1; k <= wait_c; k++) begin
            check("trace_req", trace_req, 1);
            check("cancel", cancel, k >= T);
            check("req_others", {29'd0, pf_valid, mark_done, done}, 0);
            if (k == wait_c) begin
                trace_out           = {a, 32'($urandom)};
                trace_index_i       = i;
                entry_valid         = resp == 0 || resp == 3;
                cancelled           = resp == 1 || $urandom_range(0, 1) == 1;
                processing_complete = resp >= 2;
                if (resp == 0) cancelled = 0;
            end
            step;
            {entry_valid, cancelled, processing_complete} = '0;
            trace_out = {16'($urandom), 32'($urandom)};
            trace_index_i = 4'($urandom);
        end
    endtask

    task automatic issue_phase(input logic [AW-1:0] a, input logic [IW-1:0] i, input int stall);
        for (int s = 0; s <= stall; s++) begin
            check("pf_valid", pf_valid, 1);
            check("pf_addr", pf_addr, a);
            check("pf_index", pf_index, i);
            check("issue_quiet", {29'd0, mark_done, trace_req, cancel}, 0);
            start    = s == 0 && stall > 0;
            pf_ready = s == stall;
            step;
            {start, pf_ready} = '0;
        end
        m_issued++;
    endtask

    task automatic mark_phase(input logic [AW-1:0] a, input logic [IW-1:0] i, input int m);
        for (int j = 1; j <= m; j++) begin
            check("mark_flags", {29'd0, mark_done, processing_flag, mem_trace_flag}, 3'b111);
            check("index_done", index_done, i);
            check("mem_addr", mem_addr, a);
            check("mark_pf", pf_valid, 0);
            mark_done_valid = j == m;
            step;
            mark_done_valid = 0;
        end
    endtask

    task automatic entry_pass(input int wait_c, input logic [AW-1:0] a, input logic [IW-1:0] i, input int stall);
        request_phase(wait_c, 0, a, i);
        issue_phase(a, i, stall);
        mark_phase(a, i, $urandom_range(1, 3));
        check_quiet("rearm_after_mark");
        step;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [IW-1:0] i;
        repeat (2) step;
        check_quiet("reset");
        check("reset_done", done, 0);
        check_counts;
        rst = 0;
        repeat (3) step;
        check_quiet("idle_no_start");
        check("idle_done", done, 0);

        start = 1;
        step;
        start = 0;
        check_quiet("rearm_first");
        step;
        entry_pass(3, 16'h0040, 4'd5, 0);
        check("req_after_mark", trace_req, 1);
        check_counts;

        for (int n = 0; n < 60; n++) begin
            int r, w;
            r = $urandom_range(0, 9);
            w = $urandom_range(1, 6);
            a = 16'($urandom);
            i = 4'($urandom);
            if (r < 6) begin
                entry_pass(w, a, i, $urandom_range(0, 4));
            end else if (r < 8) begin
                request_phase(w, 1, a, i);
                m_cancel++;
                check_quiet("rearm_after_cancel");
                step;
            end else begin
                request_phase(w, r == 9 ? 3 : 2, a, i);
                for (int d = 0; d < 2; d++) begin
                    check("done", done, 1);
                    check_quiet("done");
                    entry_valid = 1;
                    step;
                    entry_valid = 0;
                end
                start = 1;
                step;
                start = 0;
                check("done_cleared", done, 0);
                check_quiet("rearm_from_done");
                step;
            end
            check_counts;
        end

        entry_pass(2, 16'hBEEF, 4'd9, 10);
        check_counts;

        request_phase(2, 0, 16'h1234, 4'd3);
        issue_phase(16'h1234, 4'd3, 0);
        check("pre_reset_mark", mark_done, 1);
        #2 rst = 1;
        #1;
        check_quiet("async_reset");
        check("async_reset_addr", {pf_addr, mem_addr}, 0);
        check("async_reset_idx", {index_done, pf_index}, 0);
        m_issued = 0;
        m_cancel = 0;
        check_counts;
        step;
        rst = 0;
        mark_done_valid = 1;
        repeat (3) begin
            step;
            check_quiet("post_reset_idle");
            check("post_reset_done", done, 0);
        end
        mark_done_valid = 0;
        start = 1;
        step;
        start = 0;
        check_quiet("rearm_after_reset");
        step;
        request_phase(1, 2, 16'h0, 4'd0);
        check("final_done", done, 1);
        check_counts;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
